dmem_sram_ctrl: RTL and testbench
=================================

// Module: dmem_sram_ctrl
// PURPOSE
//  Parametrised handshake controller between a MIPS core's load/store port and a single-port
//  synchronous SRAM macro (active-low CEN/WEN/OEN). Generalises the fixed single-cycle data
//  memory hookup: configurable width/depth, programmable wait states, valid/ready request side,
//  response strobe for core stalling, out-of-range detection.
// PARAMETERS
//  DATA_W       32   data word width
//  ADDR_W       7    word address width (SRAM A port)
//  DEPTH        128  implemented words; addresses >= DEPTH are out of range
//  WAIT_CYCLES  1    extra SRAM access cycles (0..15)
// PORTS
//  clk         in   1       clock; all state updates on rising edge
//  rst         in   1       synchronous reset, active-high
//  req_valid   in   1       core request present
//  req_ready   out  1       controller can accept request this cycle
//  req_we      in   1       1 = store, 0 = load
//  req_addr    in   ADDR_W  word address
//  req_wdata   in   DATA_W  store data
//  resp_valid  out  1       one-cycle completion strobe (loads and stores)
//  resp_rdata  out  DATA_W  load data, valid with resp_valid
//  resp_err    out  1       out-of-range address, valid with resp_valid
//  CEN         out  1       SRAM chip enable, active-low
//  WEN         out  1       SRAM write enable, active-low
//  OEN         out  1       SRAM output enable, active-low
//  A           out  ADDR_W  SRAM address
//  D           out  DATA_W  SRAM write data
//  Q           in   DATA_W  SRAM read data
// BEHAVIOUR
//  - Reset (rst=1 at edge): state IDLE; CEN=WEN=OEN=1; A=0; D=0; resp_valid=0; resp_rdata=0;
//    resp_err=0; wait counter=0. Overrides everything, incl. an in-flight access (store aborted:
//    CEN high after that edge).
//  - All outputs registered; req_ready combinational = (state==IDLE || state==RESP).
//  - Accept = req_valid & req_ready; req_addr/req_we/req_wdata latched on accept edge.
//  - FSM IDLE -> ACCESS (in range) | RESP (out of range); ACCESS -> RESP; RESP -> IDLE,
//    or -> ACCESS/RESP when a new request is accepted in RESP (back-to-back).
//  - ACCESS: lasts WAIT_CYCLES+1 cycles; CEN=0, A=latched addr; store: WEN=0, OEN=1, D=wdata;
//    load: WEN=1, OEN=0. Counter loads WAIT_CYCLES on entry, decrements, exits at 0.
//  - Load data: Q sampled on the edge ending the last ACCESS cycle into resp_rdata.
//  - RESP: 1 cycle; resp_valid=1; CEN=WEN=OEN=1. Store: resp_rdata=0. resp_err=0 unless
//    out of range.
//  - Latency: accepted in cycle N -> resp_valid in cycle N+WAIT_CYCLES+2 (in range),
//    N+1 (out of range).
//  - Out of range (req_addr >= DEPTH): SRAM untouched (CEN stays 1), resp_err=1, resp_rdata=0.
//  - resp_valid, resp_err low in every non-RESP cycle; never high two cycles for one request.
//  - req_valid low or req_ready low: no state change from request side; request inputs ignored.
//  - Max throughput 1 access per WAIT_CYCLES+2 cycles.
// TESTING
//  1 Reset: rst=1 two cycles -> CEN=WEN=OEN=1, A=0, resp_valid=0, req_ready=1 after release.
//  2 Load: SRAM[0]=15, WAIT_CYCLES=1, load addr 0 in cycle N -> CEN=0,OEN=0 in cycles N+1..N+2;
//    resp_valid=1, resp_rdata=15 in N+3 only.
//  3 Store then load: store 30 to addr 4 (WEN=0, D=30 during ACCESS), then load addr 4
//    -> resp_rdata=30, resp_err=0.
//  4 Out of range: DEPTH=64, load addr 100 -> resp_valid=resp_err=1 in N+1, resp_rdata=0,
//    CEN never low.
//  5 Back-to-back: req_valid held with load addr 0 then load addr 1 (SRAM[1]=20) -> second
//    accepted in RESP cycle; resp_rdata 15 then 20, each resp_valid exactly one cycle.
//  6 Reset mid-op: rst=1 during 2nd ACCESS cycle of a store -> CEN=WEN=1 next cycle, no
//    resp_valid, SRAM word unchanged at WAIT_CYCLES=3 if asserted before final ACCESS edge.

Source files
------------

// File: rtl/dmem_sram_ctrl.sv
// Handshake controller between a core load/store port and a single-port synchronous
// SRAM macro with active-low CEN/WEN/OEN. Wait states, range check and a one-cycle
// response strobe are provided. All outputs except req_ready are registered.
module dmem_sram_ctrl #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned DEPTH       = 128,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              CEN,
    output logic              WEN,
    output logic              OEN,
    output logic [ADDR_W-1:0] A,
    output logic [DATA_W-1:0] D,
    input  logic [DATA_W-1:0] Q
);

    // One extra bit so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] DepthLim = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      WaitInit = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic              cen_q, cen_d;
    logic              wen_q, wen_d;
    logic              oen_q, oen_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] d_q, d_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rerr_q, rerr_d;
    logic              accept;
    logic              in_range;

    assign req_ready  = (state_q == StIdle) || (state_q == StResp);
    assign accept     = req_valid && req_ready;
    assign in_range   = {1'b0, req_addr} < DepthLim;

    assign CEN        = cen_q;
    assign WEN        = wen_q;
    assign OEN        = oen_q;
    assign A          = a_q;
    assign D          = d_q;
    assign resp_valid = rvalid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = rerr_q;

    // Next-state and registered-output values for the access FSM.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        cen_d    = cen_q;
        wen_d    = wen_q;
        oen_d    = oen_q;
        a_d      = a_q;
        d_d      = d_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        rerr_d   = 1'b0;

        unique case (state_q)
            StAccess: begin
                if (cnt_q == 4'd0) begin
                    // Last access cycle: capture Q and release the macro.
                    state_d  = StResp;
                    rvalid_d = 1'b1;
                    rdata_d  = we_q ? '0 : Q;
                    cen_d    = 1'b1;
                    wen_d    = 1'b1;
                    oen_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cen_d   = 1'b1;
                wen_d   = 1'b1;
                oen_d   = 1'b1;
            end
        endcase

        // Only reachable from IDLE/RESP, so never collides with the ACCESS branch.
        if (accept) begin
            we_d = req_we;
            if (in_range) begin
                state_d = StAccess;
                cnt_d   = WaitInit;
                cen_d   = 1'b0;
                wen_d   = ~req_we;
                oen_d   = req_we;
                a_d     = req_addr;
                d_d     = req_wdata;
            end else begin
                // Out of range: respond immediately, SRAM never enabled.
                state_d  = StResp;
                rvalid_d = 1'b1;
                rerr_d   = 1'b1;
                rdata_d  = '0;
            end
        end
    end

    // State and output registers; synchronous reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            we_q     <= 1'b0;
            cen_q    <= 1'b1;
            wen_q    <= 1'b1;
            oen_q    <= 1'b1;
            a_q      <= '0;
            d_q      <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            cen_q    <= cen_d;
            wen_q    <= wen_d;
            oen_q    <= oen_d;
            a_q      <= a_d;
            d_q      <= d_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rerr_q   <= rerr_d;
        end
    end

endmodule

// File: tb/tb_dmem_sram_ctrl.sv
// Directed bench for dmem_sram_ctrl. Two instances share the request side:
// dut_a (DEPTH=64, WAIT_CYCLES=1) and dut_b (DEPTH=128, WAIT_CYCLES=3). Each has its
// own SRAM model that commits a write only after WAIT_CYCLES+1 consecutive enabled cycles.
module tb_dmem_sram_ctrl;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;

    logic          ready_a, rvalid_a, rerr_a, cen_a, wen_a, oen_a;
    logic [DW-1:0] rdata_a, d_a, q_a;
    logic [AW-1:0] a_a;
    logic          ready_b, rvalid_b, rerr_b, cen_b, wen_b, oen_b;
    logic [DW-1:0] rdata_b, d_b, q_b;
    logic [AW-1:0] a_b;

    logic [DW-1:0] mem_a [0:127];
    logic [DW-1:0] mem_b [0:127];
    int            act_a = 0;
    int            act_b = 0;
    logic          pre_en = 1'b0;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    dmem_sram_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(64), .WAIT_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_a), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rvalid_a),
        .resp_rdata(rdata_a), .resp_err(rerr_a), .CEN(cen_a), .WEN(wen_a), .OEN(oen_a),
        .A(a_a), .D(d_a), .Q(q_a)
    );

    dmem_sram_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(128), .WAIT_CYCLES(3)) dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_b), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rvalid_b),
        .resp_rdata(rdata_b), .resp_err(rerr_b), .CEN(cen_b), .WEN(wen_b), .OEN(oen_b),
        .A(a_b), .D(d_b), .Q(q_b)
    );

    // SRAM model A: reads every enabled edge, write lands on the 2nd enabled cycle.
    always @(posedge clk) begin
        if (pre_en) begin
            mem_a[pre_addr] <= pre_data;
        end else if (!cen_a) begin
            if (wen_a) q_a <= mem_a[a_a];
            else if (act_a == 1) mem_a[a_a] <= d_a;
            act_a <= act_a + 1;
        end else begin
            act_a <= 0;
        end
    end

    // SRAM model B: write lands on the 4th enabled cycle.
    always @(posedge clk) begin
        if (pre_en) begin
            mem_b[pre_addr] <= pre_data;
        end else if (!cen_b) begin
            if (wen_b) q_b <= mem_b[a_b];
            else if (act_b == 3) mem_b[a_b] <= d_b;
            act_b <= act_b + 1;
        end else begin
            act_b <= 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        pre_addr = addr;
        pre_data = data;
        pre_en   = 1'b1;
        tick();
        pre_en   = 1'b0;
    endtask

    // Present one request for a single cycle; returns in cycle N+1.
    task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = data;
        tick();
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int hits;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;

        // Reset for two cycles.
        tick();
        tick();
        rst = 1'b0;
        check_eq("rst_cen", cen_a, 1'b1);
        check_eq("rst_wen", wen_a, 1'b1);
        check_eq("rst_oen", oen_a, 1'b1);
        check_eq("rst_a", a_a, 0);
        check_eq("rst_d", d_a, 0);
        check_eq("rst_rvalid", rvalid_a, 1'b0);
        check_eq("rst_rerr", rerr_a, 1'b0);
        check_eq("rst_rdata", rdata_a, 0);
        check_eq("rst_ready", ready_a, 1'b1);
        check_eq("rst_rvalid_b", rvalid_b, 1'b0);

        preload(7'd0, 32'd15);
        preload(7'd1, 32'd20);
        preload(7'd9, 32'd55);
        preload(7'd63, 32'd7);

        // Load addr 0, one wait state: ACCESS in N+1..N+2, response in N+3.
        issue(1'b0, 7'd0, '0);
        check_eq("ld_n1_cen", cen_a, 1'b0);
        check_eq("ld_n1_oen", oen_a, 1'b0);
        check_eq("ld_n1_wen", wen_a, 1'b1);
        check_eq("ld_n1_ready", ready_a, 1'b0);
        check_eq("ld_n1_rvalid", rvalid_a, 1'b0);
        tick();
        check_eq("ld_n2_cen", cen_a, 1'b0);
        check_eq("ld_n2_oen", oen_a, 1'b0);
        check_eq("ld_n2_rvalid", rvalid_a, 1'b0);
        tick();
        check_eq("ld_n3_rvalid", rvalid_a, 1'b1);
        check_eq("ld_n3_rdata", rdata_a, 32'd15);
        check_eq("ld_n3_rerr", rerr_a, 1'b0);
        check_eq("ld_n3_cen", cen_a, 1'b1);
        tick();
        check_eq("ld_n4_rvalid", rvalid_a, 1'b0);

        // Store 30 to addr 4, then read it back.
        issue(1'b1, 7'd4, 32'd30);
        check_eq("st_n1_cen", cen_a, 1'b0);
        check_eq("st_n1_wen", wen_a, 1'b0);
        check_eq("st_n1_oen", oen_a, 1'b1);
        check_eq("st_n1_d", d_a, 32'd30);
        check_eq("st_n1_a", a_a, 4);
        tick();
        check_eq("st_n2_wen", wen_a, 1'b0);
        tick();
        check_eq("st_n3_rvalid", rvalid_a, 1'b1);
        check_eq("st_n3_rdata", rdata_a, 0);
        check_eq("st_n3_wen", wen_a, 1'b1);
        tick();
        issue(1'b0, 7'd4, '0);
        tick();
        tick();
        check_eq("stld_rvalid", rvalid_a, 1'b1);
        check_eq("stld_rdata", rdata_a, 32'd30);
        check_eq("stld_rerr", rerr_a, 1'b0);
        tick();

        // Out of range (DEPTH=64): addr 100 and boundary 64 respond in N+1 with error.
        issue(1'b0, 7'd100, '0);
        check_eq("oor_rvalid", rvalid_a, 1'b1);
        check_eq("oor_rerr", rerr_a, 1'b1);
        check_eq("oor_rdata", rdata_a, 0);
        check_eq("oor_cen", cen_a, 1'b1);
        tick();
        check_eq("oor_n2_rvalid", rvalid_a, 1'b0);
        check_eq("oor_n2_rerr", rerr_a, 1'b0);
        check_eq("oor_n2_cen", cen_a, 1'b1);
        issue(1'b1, 7'd64, 32'd99);
        check_eq("oor64_rerr", rerr_a, 1'b1);
        check_eq("oor64_cen", cen_a, 1'b1);
        tick();
        issue(1'b0, 7'd63, '0);
        tick();
        tick();
        check_eq("in63_rvalid", rvalid_a, 1'b1);
        check_eq("in63_rerr", rerr_a, 1'b0);
        check_eq("in63_rdata", rdata_a, 32'd7);
        tick();

        // Back-to-back: valid held, second request accepted in the RESP cycle.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 7'd0;
        tick();
        req_addr = 7'd1;
        check_eq("b2b_n1_rvalid", rvalid_a, 1'b0);
        tick();
        tick();
        check_eq("b2b_n3_rvalid", rvalid_a, 1'b1);
        check_eq("b2b_n3_rdata", rdata_a, 32'd15);
        check_eq("b2b_n3_ready", ready_a, 1'b1);
        tick();
        req_valid = 1'b0;
        check_eq("b2b_n4_rvalid", rvalid_a, 1'b0);
        check_eq("b2b_n4_cen", cen_a, 1'b0);
        check_eq("b2b_n4_a", a_a, 1);
        tick();
        check_eq("b2b_n5_rvalid", rvalid_a, 1'b0);
        tick();
        check_eq("b2b_n6_rvalid", rvalid_a, 1'b1);
        check_eq("b2b_n6_rdata", rdata_a, 32'd20);
        tick();
        check_eq("b2b_n7_rvalid", rvalid_a, 1'b0);

        // Reset during the 2nd ACCESS cycle of a store on the 3-wait-state instance.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        issue(1'b1, 7'd9, 32'd77);
        check_eq("abort_n1_cen", cen_b, 1'b0);
        check_eq("abort_n1_wen", wen_b, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("abort_cen", cen_b, 1'b1);
        check_eq("abort_wen", wen_b, 1'b1);
        check_eq("abort_rvalid", rvalid_b, 1'b0);
        hits = 0;
        for (int i = 0; i < 6; i++) begin
            if (rvalid_b) hits++;
            tick();
        end
        check_eq("abort_no_resp", hits, 0);
        check_eq("abort_mem", mem_b[9], 32'd55);
        issue(1'b0, 7'd9, '0);
        lat = 1;
        while (!rvalid_b && lat < 20) begin
            tick();
            lat++;
        end
        check_eq("w3_latency", lat, 5);
        check_eq("w3_rdata", rdata_b, 32'd55);
        check_eq("w3_rerr", rerr_b, 1'b0);
        tick();
        check_eq("w3_rvalid_drop", rvalid_b, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
